// File: rtl/sram_2p_march_bist_ctrl_pkg.sv
// March C- BIST shared definitions: element and FSM encodings, per-element
// traits (bit i of each mask describes element Ei), and PORT_SEL codes.
package sram_bist_pkg;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    localparam logic [5:0] ELEM_DOWN    = 6'b011000;
    localparam logic [5:0] ELEM_TWO_OPS = 6'b011110;
    localparam logic [5:0] ELEM_RD_ONE  = 6'b010100;
    localparam logic [5:0] ELEM_WR_ONE  = 6'b001010;

    localparam logic [1:0] PSEL_NONE = 2'b00;
    localparam logic [1:0] PSEL_A    = 2'b01;
    localparam logic [1:0] PSEL_B    = 2'b10;
    localparam logic [1:0] PSEL_AB   = 2'b11;

    // Two-op elements read first then write; E5 is a lone read, E0 a lone write.
    function automatic logic op_is_read(elem_e e, logic op);
        return (e == E5) || (ELEM_TWO_OPS[e] && !op);
    endfunction

endpackage

// File: rtl/sram_2p_march_bist_ctrl_if.sv
// Host-control, macro-request and status bundle of the March C- BIST controller.
interface sram_2p_march_bist_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
);
    logic              START;
    logic [1:0]        PORT_SEL;
    logic [DATA_W-1:0] A_DOUT;
    logic [DATA_W-1:0] B_DOUT;
    logic              BIST_EN;
    logic              BIST_A_MEN;
    logic              BIST_B_MEN;
    logic              BIST_WEN;
    logic              BIST_REN;
    logic [ADDR_W-1:0] BIST_ADDR;
    logic [DATA_W-1:0] BIST_DIN;
    logic [DATA_W-1:0] BIST_BM;
    logic              BUSY;
    logic              DONE;
    logic              FAIL;
    logic              FAIL_PORT;
    logic [ADDR_W-1:0] FAIL_ADDR;
    logic [CNT_W-1:0]  FAIL_COUNT;

    modport master (
        input  START, PORT_SEL, A_DOUT, B_DOUT,
        output BIST_EN, BIST_A_MEN, BIST_B_MEN, BIST_WEN, BIST_REN, BIST_ADDR,
               BIST_DIN, BIST_BM, BUSY, DONE, FAIL, FAIL_PORT, FAIL_ADDR, FAIL_COUNT
    );

    modport slave (
        output START, PORT_SEL, A_DOUT, B_DOUT,
        input  BIST_EN, BIST_A_MEN, BIST_B_MEN, BIST_WEN, BIST_REN, BIST_ADDR,
               BIST_DIN, BIST_BM, BUSY, DONE, FAIL, FAIL_PORT, FAIL_ADDR, FAIL_COUNT
    );
endinterface

// File: rtl/sram_2p_march_bist_ctrl_cmp.sv
// Read-compare pipeline: delays each issued read until its DOUT is valid,
// detects mismatches and keeps sticky fail, first-fail location and a saturating count.
module sram_bist_cmp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              push_port,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              push_exp,
    input  logic [DATA_W-1:0] a_dout,
    input  logic [DATA_W-1:0] b_dout,
    output logic              fail,
    output logic              fail_port,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [CNT_W-1:0]  fail_count
);
    logic              valid_reg [RD_LAT+1];
    logic              port_reg  [RD_LAT+1];
    logic [ADDR_W-1:0] addr_reg  [RD_LAT+1];
    logic              exp_reg   [RD_LAT+1];

    // Stage 0 loads alongside the command registers, so stage RD_LAT lines up with DOUT.
    for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    port_reg[gi]  <= 1'b0;
                    addr_reg[gi]  <= '0;
                    exp_reg[gi]   <= 1'b0;
                end else begin
                    valid_reg[gi] <= push;
                    port_reg[gi]  <= push_port;
                    addr_reg[gi]  <= push_addr;
                    exp_reg[gi]   <= push_exp;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    port_reg[gi]  <= 1'b0;
                    addr_reg[gi]  <= '0;
                    exp_reg[gi]   <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    port_reg[gi]  <= port_reg[gi-1];
                    addr_reg[gi]  <= addr_reg[gi-1];
                    exp_reg[gi]   <= exp_reg[gi-1];
                end
            end
        end
    end

    logic [DATA_W-1:0] dout_sel;
    logic              mismatch;
    logic              fail_reg;
    logic              fail_port_reg;
    logic [ADDR_W-1:0] fail_addr_reg;
    logic [CNT_W-1:0]  fail_count_reg;

    assign dout_sel = port_reg[RD_LAT] ? b_dout : a_dout;
    assign mismatch = valid_reg[RD_LAT] && (dout_sel != {DATA_W{exp_reg[RD_LAT]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_reg       <= 1'b0;
            fail_port_reg  <= 1'b0;
            fail_addr_reg  <= '0;
            fail_count_reg <= '0;
        end else if (clr) begin
            fail_reg       <= 1'b0;
            fail_port_reg  <= 1'b0;
            fail_addr_reg  <= '0;
            fail_count_reg <= '0;
        end else if (mismatch) begin
            fail_reg <= 1'b1;
            if (!fail_reg) begin
                fail_port_reg <= port_reg[RD_LAT];
                fail_addr_reg <= addr_reg[RD_LAT];
            end
            if (fail_count_reg != {CNT_W{1'b1}})
                fail_count_reg <= fail_count_reg + 1'b1;
        end
    end

    assign fail       = fail_reg;
    assign fail_port  = fail_port_reg;
    assign fail_addr  = fail_addr_reg;
    assign fail_count = fail_count_reg;

endmodule

// File: rtl/sram_2p_march_bist_ctrl.sv
// March C- BIST controller for a two-port SRAM macro: FSM, element/address/op
// sequencing and registered command outputs; read checking lives in sram_bist_cmp.
module sram_2p_march_bist_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic BIST_CLK,
    input  logic BIST_RST_N,
    sram_2p_march_bist_ctrl_if.master bus
);
    import sram_bist_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_e            state_reg;
    elem_e             elem_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              op_reg;
    logic              port_reg;
    logic              both_reg;
    logic [1:0]        drain_reg;
    logic              en_reg;
    logic              a_men_reg;
    logic              b_men_reg;
    logic              wen_reg;
    logic              ren_reg;
    logic [DATA_W-1:0] din_reg;
    logic [DATA_W-1:0] bm_reg;
    logic              done_reg;

    // Successor of the command currently on the bus.
    elem_e             elem_next;
    logic [ADDR_W-1:0] addr_next;
    logic              op_next;
    logic              elem_wrap;

    always_comb begin
        elem_next = elem_reg;
        addr_next = addr_reg;
        op_next   = 1'b0;
        elem_wrap = 1'b0;
        if (ELEM_TWO_OPS[elem_reg] && !op_reg) begin
            op_next = 1'b1;
        end else if (addr_reg == (ELEM_DOWN[elem_reg] ? '0 : ADDR_LAST)) begin
            if (elem_reg == E5) begin
                elem_wrap = 1'b1;
                elem_next = E0;
            end else begin
                elem_next = elem_e'(elem_reg + 3'd1);
            end
            addr_next = ELEM_DOWN[elem_next] ? ADDR_LAST : '0;
        end else if (ELEM_DOWN[elem_reg]) begin
            addr_next = addr_reg - 1'b1;
        end else begin
            addr_next = addr_reg + 1'b1;
        end
    end

    logic              start_ok;
    logic              run_end;
    logic              iss_valid;
    elem_e             iss_elem;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_op;
    logic              iss_port;
    logic              iss_rd;

    assign start_ok = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && bus.START;
    // Wrapping past E5 on port A with both ports selected rolls straight into port B.
    assign run_end  = (state_reg == ST_RUN) && elem_wrap && !(both_reg && !port_reg);

    always_comb begin
        iss_valid = 1'b0;
        iss_elem  = E0;
        iss_addr  = '0;
        iss_op    = 1'b0;
        iss_port  = port_reg;
        if (start_ok && (bus.PORT_SEL != PSEL_NONE)) begin
            iss_valid = 1'b1;
            iss_port  = (bus.PORT_SEL == PSEL_B);
        end else if ((state_reg == ST_RUN) && !run_end) begin
            iss_valid = 1'b1;
            iss_elem  = elem_next;
            iss_addr  = addr_next;
            iss_op    = op_next;
            iss_port  = port_reg | elem_wrap;
        end
    end

    assign iss_rd = op_is_read(iss_elem, iss_op);

    always_ff @(posedge BIST_CLK or negedge BIST_RST_N) begin
        if (!BIST_RST_N) begin
            state_reg <= ST_IDLE;
            elem_reg  <= E0;
            addr_reg  <= '0;
            op_reg    <= 1'b0;
            port_reg  <= 1'b0;
            both_reg  <= 1'b0;
            drain_reg <= '0;
            en_reg    <= 1'b0;
            a_men_reg <= 1'b0;
            b_men_reg <= 1'b0;
            wen_reg   <= 1'b0;
            ren_reg   <= 1'b0;
            din_reg   <= '0;
            bm_reg    <= '1;
            done_reg  <= 1'b0;
        end else begin
            bm_reg    <= '1;
            a_men_reg <= iss_valid && !iss_port;
            b_men_reg <= iss_valid && iss_port;
            wen_reg   <= iss_valid && !iss_rd;
            ren_reg   <= iss_valid && iss_rd;
            din_reg   <= (iss_valid && !iss_rd && ELEM_WR_ONE[iss_elem]) ? '1 : '0;
            if (iss_valid) begin
                elem_reg <= iss_elem;
                addr_reg <= iss_addr;
                op_reg   <= iss_op;
                port_reg <= iss_port;
            end
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        both_reg <= (bus.PORT_SEL == PSEL_AB);
                        if (bus.PORT_SEL == PSEL_NONE) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                            en_reg    <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (run_end) begin
                        state_reg <= ST_DRAIN;
                        drain_reg <= 2'(RD_LAT - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == 2'd0) begin
                        state_reg <= ST_DONE;
                        en_reg    <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        drain_reg <= drain_reg - 2'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    sram_bist_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) u_cmp (
        .clk        (BIST_CLK),
        .rst_n      (BIST_RST_N),
        .clr        (start_ok),
        .push       (iss_valid && iss_rd),
        .push_port  (iss_port),
        .push_addr  (iss_addr),
        .push_exp   (ELEM_RD_ONE[iss_elem]),
        .a_dout     (bus.A_DOUT),
        .b_dout     (bus.B_DOUT),
        .fail       (bus.FAIL),
        .fail_port  (bus.FAIL_PORT),
        .fail_addr  (bus.FAIL_ADDR),
        .fail_count (bus.FAIL_COUNT)
    );

    assign bus.BIST_EN    = en_reg;
    assign bus.BUSY       = en_reg;
    assign bus.BIST_A_MEN = a_men_reg;
    assign bus.BIST_B_MEN = b_men_reg;
    assign bus.BIST_WEN   = wen_reg;
    assign bus.BIST_REN   = ren_reg;
    assign bus.BIST_ADDR  = addr_reg;
    assign bus.BIST_DIN   = din_reg;
    assign bus.BIST_BM    = bm_reg;
    assign bus.DONE       = done_reg;

endmodule

// File: tb/tb_sram_2p_march_bist_ctrl.sv
// Bench for the March C- BIST controller: RD_LAT=1 and RD_LAT=2 instances on
// behavioural macros with injectable faults; command and status scoreboards.
module tb_sram_2p_march_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] port_sel = 2'b00;
    logic       fault_stuck = 1'b0;
    logic       fault_inv = 1'b0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic        en_w [2], amen_w [2], bmen_w [2], wen_w [2], ren_w [2];
    logic        busy_w [2], done_w [2], fail_w [2], fport_w [2];
    logic [7:0]  addr_w [2], faddr_w [2], fcnt_w [2];
    logic [31:0] din_w [2], bm_w [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        sram_2p_march_bist_ctrl_if #(.DATA_W(32), .ADDR_W(8), .CNT_W(8)) bus ();
        logic [31:0] mem [256];
        logic [31:0] a_q, b_q, a_q2, b_q2;

        assign bus.START    = start;
        assign bus.PORT_SEL = port_sel;
        assign bus.A_DOUT   = (gi == 0) ? a_q : a_q2;
        assign bus.B_DOUT   = (gi == 0) ? b_q : b_q2;

        sram_2p_march_bist_ctrl #(.DATA_W(32), .ADDR_W(8), .RD_LAT(gi + 1), .CNT_W(8)) dut (
            .BIST_CLK   (clk),
            .BIST_RST_N (rst_n),
            .bus        (bus)
        );

        // Shared array; port A can force bit 3 high at 0x2A, port B can invert reads.
        always @(posedge clk) begin
            if (bus.BIST_WEN && (bus.BIST_A_MEN || bus.BIST_B_MEN))
                mem[bus.BIST_ADDR] <= (mem[bus.BIST_ADDR] & ~bus.BIST_BM) | (bus.BIST_DIN & bus.BIST_BM);
            if (bus.BIST_REN && bus.BIST_A_MEN)
                a_q <= (fault_stuck && bus.BIST_ADDR == 8'h2A) ? (mem[bus.BIST_ADDR] | 32'h8) : mem[bus.BIST_ADDR];
            if (bus.BIST_REN && bus.BIST_B_MEN)
                b_q <= fault_inv ? ~mem[bus.BIST_ADDR] : mem[bus.BIST_ADDR];
            a_q2 <= a_q;
            b_q2 <= b_q;
        end

        assign en_w[gi]    = bus.BIST_EN;
        assign amen_w[gi]  = bus.BIST_A_MEN;
        assign bmen_w[gi]  = bus.BIST_B_MEN;
        assign wen_w[gi]   = bus.BIST_WEN;
        assign ren_w[gi]   = bus.BIST_REN;
        assign addr_w[gi]  = bus.BIST_ADDR;
        assign din_w[gi]   = bus.BIST_DIN;
        assign bm_w[gi]    = bus.BIST_BM;
        assign busy_w[gi]  = bus.BUSY;
        assign done_w[gi]  = bus.DONE;
        assign fail_w[gi]  = bus.FAIL;
        assign fport_w[gi] = bus.FAIL_PORT;
        assign faddr_w[gi] = bus.FAIL_ADDR;
        assign fcnt_w[gi]  = bus.FAIL_COUNT;
    end

    typedef struct packed {
        logic        a_men;
        logic        b_men;
        logic        wen;
        logic        ren;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] bm;
    } cmd_t;

    typedef struct packed {
        logic [15:0] cyc;
        logic        fail;
        logic        fport;
        logic [7:0]  faddr;
        logic [7:0]  fcnt;
    } res_t;

    cmd_t cmd_q [$];
    res_t res_q [$];
    bit   mon_on = 1'b0;
    cmd_t mon_obs, mon_exp;

    // March C- reference: op codes 0=w0 1=w1 2=r0 3=r1.
    int nops [6] = '{1, 2, 2, 2, 2, 1};
    bit down [6] = '{0, 0, 0, 1, 1, 0};
    int opc [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};

    task automatic push_march(input bit pb);
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < 256; i++)
                for (int o = 0; o < nops[e]; o++) begin
                    cmd_t c;
                    c.a_men = !pb;
                    c.b_men = pb;
                    c.wen   = (opc[e][o] < 2);
                    c.ren   = (opc[e][o] >= 2);
                    c.addr  = down[e] ? 8'(255 - i) : 8'(i);
                    c.din   = (opc[e][o] == 1) ? 32'hFFFF_FFFF : 32'h0;
                    c.bm    = 32'hFFFF_FFFF;
                    cmd_q.push_back(c);
                end
    endtask

    // Instance 0 command monitor: every MEN cycle must match the next expected command.
    always @(negedge clk) begin
        if (mon_on && (amen_w[0] || bmen_w[0])) begin
            mon_obs = '{amen_w[0], bmen_w[0], wen_w[0], ren_w[0], addr_w[0],
                        wen_w[0] ? din_w[0] : 32'h0, bm_w[0]};
            total++;
            if (cmd_q.size() == 0) begin
                bad++;
                $display("FAIL cmd_extra: got %h want none", mon_obs);
            end else begin
                mon_exp = cmd_q.pop_front();
                if (mon_obs !== mon_exp) begin
                    bad++;
                    $display("FAIL cmd_seq: got %h want %h", mon_obs, mon_exp);
                end
            end
        end
    end

    task automatic kick(input logic [1:0] ps);
        @(negedge clk);
        start = 1'b1;
        port_sel = ps;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input int idx, input int limit);
        while (done_w[idx] !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [64:0] rv;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            rv = {en_w[i], amen_w[i], bmen_w[i], wen_w[i], ren_w[i], busy_w[i], done_w[i],
                  fail_w[i], fport_w[i], addr_w[i], din_w[i], faddr_w[i], fcnt_w[i]};
            total++;
            if (rv !== 65'd0) begin bad++; $display("FAIL reset_out[%0d]: got %h want 0", i, rv); end
            total++;
            if (bm_w[i] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_bm[%0d]: got %h want ffffffff", i, bm_w[i]); end
        end
        rst_n = 1'b1;
        $display("run reset: outputs sampled under reset");
    endtask

    task automatic test_clean_a();
        res_t obs, exp;
        cmd_q.delete();
        mon_on = 1'b1;
        push_march(1'b0);
        res_q.push_back('{16'd2562, 1'b0, 1'b0, 8'h00, 8'd0});
        kick(2'b01);
        wait_done(0, 6000);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL clean_a status: got %h want %h", obs, exp); end
        total++;
        if (cmd_q.size() != 0) begin bad++; $display("FAIL clean_a missing_cmds: got %0d want 0", cmd_q.size()); end
        $display("run clean_a: done_cycle=%0d fail=%0d count=%0d", cyc, fail_w[0], fcnt_w[0]);
    endtask

    task automatic test_stuck_a();
        res_t obs, exp;
        cmd_q.delete();
        fault_stuck = 1'b1;
        push_march(1'b0);
        res_q.push_back('{16'd2562, 1'b1, 1'b0, 8'h2A, 8'd3});
        kick(2'b01);
        wait_done(0, 6000);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stuck_a status: got %h want %h", obs, exp); end
        total++;
        if (cmd_q.size() != 0) begin bad++; $display("FAIL stuck_a missing_cmds: got %0d want 0", cmd_q.size()); end
        fault_stuck = 1'b0;
        $display("run stuck_a: done_cycle=%0d addr=%h count=%0d", cyc, faddr_w[0], fcnt_w[0]);
    endtask

    task automatic test_port_none();
        res_t obs, exp;
        cmd_q.delete();
        res_q.push_back('{16'd1, 1'b0, 1'b0, 8'h00, 8'd0});
        kick(2'b00);
        wait_done(0, 20);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL none status: got %h want %h", obs, exp); end
        total++;
        if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL none busy: got %b want 0", busy_w[0]); end
        repeat (5) @(negedge clk);
        $display("run port_none: done_cycle=%0d", cyc);
    endtask

    task automatic test_inv_b();
        res_t obs, exp;
        cmd_q.delete();
        fault_inv = 1'b1;
        push_march(1'b0);
        push_march(1'b1);
        res_q.push_back('{16'd5122, 1'b1, 1'b1, 8'h00, 8'd255});
        kick(2'b11);
        wait_done(0, 12000);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL inv_b status: got %h want %h", obs, exp); end
        total++;
        if (cmd_q.size() != 0) begin bad++; $display("FAIL inv_b missing_cmds: got %0d want 0", cmd_q.size()); end
        fault_inv = 1'b0;
        $display("run inv_b: done_cycle=%0d port=%0d count=%0d", cyc, fport_w[0], fcnt_w[0]);
    endtask

    task automatic test_start_ignored();
        res_t obs, exp;
        cmd_q.delete();
        push_march(1'b0);
        res_q.push_back('{16'd2562, 1'b0, 1'b0, 8'h00, 8'd0});
        kick(2'b01);
        repeat (99) @(negedge clk);
        start = 1'b1;
        port_sel = 2'b10;
        @(negedge clk);
        start = 1'b0;
        cyc = 101;
        wait_done(0, 6000);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL start_ign status: got %h want %h", obs, exp); end
        total++;
        if (cmd_q.size() != 0) begin bad++; $display("FAIL start_ign missing_cmds: got %0d want 0", cmd_q.size()); end
        $display("run start_ignored: done_cycle=%0d", cyc);
    endtask

    task automatic test_reset_mid();
        res_t obs, exp;
        logic [64:0] rv;
        cmd_q.delete();
        push_march(1'b0);
        kick(2'b01);
        repeat (699) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            rv = {en_w[i], amen_w[i], bmen_w[i], wen_w[i], ren_w[i], busy_w[i], done_w[i],
                  fail_w[i], fport_w[i], addr_w[i], din_w[i], faddr_w[i], fcnt_w[i]};
            total++;
            if (rv !== 65'd0) begin bad++; $display("FAIL abort_out[%0d]: got %h want 0", i, rv); end
            total++;
            if (bm_w[i] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL abort_bm[%0d]: got %h want ffffffff", i, bm_w[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cmd_q.delete();
        push_march(1'b0);
        res_q.push_back('{16'd2562, 1'b0, 1'b0, 8'h00, 8'd0});
        kick(2'b01);
        wait_done(0, 6000);
        obs = '{16'(cyc), fail_w[0], fport_w[0], faddr_w[0], fcnt_w[0]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rerun status: got %h want %h", obs, exp); end
        total++;
        if (cmd_q.size() != 0) begin bad++; $display("FAIL rerun missing_cmds: got %0d want 0", cmd_q.size()); end
        $display("run reset_mid: rerun done_cycle=%0d", cyc);
    endtask

    task automatic test_rd_lat2();
        res_t obs, exp;
        cmd_q.delete();
        push_march(1'b0);
        res_q.push_back('{16'd2563, 1'b0, 1'b0, 8'h00, 8'd0});
        kick(2'b01);
        wait_done(1, 6000);
        obs = '{16'(cyc), fail_w[1], fport_w[1], faddr_w[1], fcnt_w[1]};
        exp = res_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL rd_lat2 status: got %h want %h", obs, exp); end
        total++;
        if (busy_w[1] !== 1'b0) begin bad++; $display("FAIL rd_lat2 busy: got %b want 0", busy_w[1]); end
        $display("run rd_lat2: done_cycle=%0d fail=%0d", cyc, fail_w[1]);
    endtask

    initial begin
        test_reset();
        test_clean_a();
        test_stuck_a();
        test_port_none();
        test_inv_b();
        test_start_ignored();
        test_reset_mid();
        test_rd_lat2();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_2p_march_bist_ctrl.md
# sram_2p_march_bist_ctrl

March C- built-in self-test controller for the two-port SRAM macros with BIST ports (e.g. 256x32 with bit mask). It drives the macro's A_BIST_*/B_BIST_* request pins, samples A_DOUT/B_DOUT, and compares each read against expected data. It reports pass/fail, the first failing address and port, and a saturating error count. It sits beside each macro instance and is clocked by the same clock that feeds A_BIST_CLK and B_BIST_CLK.

## Interface
- DATA_W, 32: macro word width.
- ADDR_W, 8: macro address width; depth = 2**ADDR_W.
- RD_LAT, 1: cycles from read-command sample edge to DOUT valid; legal values are 1 and 2.
- CNT_W, 8: FAIL_COUNT width.

Ports:
- BIST_CLK  in  1  clock; also feeds A_BIST_CLK and B_BIST_CLK.
- BIST_RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle start request.
- PORT_SEL  in  2  01 = port A, 10 = port B, 11 = A then B, 00 = none. Sampled with START.
- A_DOUT, B_DOUT  in  DATA_W  macro read data.
- BIST_EN  out  1  tied to A_BIST_EN and B_BIST_EN.
- BIST_A_MEN, BIST_B_MEN  out  1  per-port memory enable.
- BIST_WEN, BIST_REN  out  1  shared by both ports.
- BIST_ADDR  out  ADDR_W  shared address.
- BIST_DIN, BIST_BM  out  DATA_W  shared write data and mask. BM is all ones whenever BIST_EN is high.
- BUSY, DONE, FAIL, FAIL_PORT  out  1  status.
- FAIL_ADDR  out  ADDR_W  first failing address.
- FAIL_COUNT  out  CNT_W  saturating count of failing read words.

## Operation
- All outputs are registered. Reset value of every output is 0, except BIST_BM, which resets to all ones.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, START=1, PORT_SEL≠00: go to RUN. Clear FAIL, FAIL_PORT, FAIL_ADDR and FAIL_COUNT. Latch PORT_SEL. The first port is A unless PORT_SEL=10.
  - IDLE or DONE, START=1, PORT_SEL=00: go directly to DONE. No memory access is issued. Status is cleared.
  - RUN: issue one command per cycle.
    - At the end of the last element on the first port, if PORT_SEL=11: restart at element 0 on port B in the next cycle, with no bubble.
    - Otherwise go to DRAIN.
  - DRAIN: hold all MENs at 0 for RD_LAT cycles, then go to DONE.
  - DONE: hold DONE=1 until the next START.
- START is ignored in RUN and DRAIN.
- BUSY=1 in RUN and DRAIN. BIST_EN equals BUSY.
- March elements, with ops per address:
  - E0 ⇑ w0
  - E1 ⇑ r0,w1
  - E2 ⇑ r1,w0
  - E3 ⇓ r0,w1
  - E4 ⇓ r1,w0
  - E5 ⇑ r0
- Data pattern: "0" is all-zero words and "1" is all-ones words.
- Address order: ⇑ counts 0 to depth-1; ⇓ counts depth-1 to 0. Wrap-around ends the element and never repeats an address.
- Command encoding:
  - Read: MEN=1, REN=1, WEN=0.
  - Write: MEN=1, WEN=1, REN=0, DIN = pattern.
  - Only the active port's MEN is high.
- Compare pipeline:
  - Each read pushes {port, addr, expected} into an RD_LAT+1 stage delay line.
  - At the stage where the selected port's DOUT is valid, a mismatch in any bit counts as a failure.
- On each failure:
  - FAIL is set (sticky).
  - FAIL_COUNT increments and saturates at 2**CNT_W-1.
  - FAIL_ADDR and FAIL_PORT are captured on the first failure only.
- Reset mid-run aborts immediately, with all outputs at reset values. No partial status is retained.

## Timing
- Cycle 0 is the edge that samples START.
- Commands are visible in cycles 1..10·depth per port:
  - depth=256: cycles 1..2560.
  - PORT_SEL=11: port B occupies cycles 2561..5120.
- Last read is issued in cycle N = 10·depth·ports. Its compare occurs at the end of cycle N+RD_LAT.
- DONE rises and BUSY falls in cycle N+RD_LAT+1:
  - 2562 for a single port with RD_LAT=1.
  - 5122 for both ports.
- PORT_SEL=00: DONE rises in cycle 1.
- Failure status updates in the cycle after the compare edge.
- DONE and the final status change in the same cycle.

## Structure
- Package sram_bist_pkg holds:
  - the element enum (E0..E5)
  - the FSM state enum
  - per-element constants: direction, op count, read expectation, write value
  - the PORT_SEL encodings
- One sub-module, sram_bist_cmp: the RD_LAT delay line, mismatch detect, and fail capture/counter.
- The top level holds the FSM, element/address/op counters, and command registers.

## Test plan
- Clean behavioral macro, PORT_SEL=01, RD_LAT=1:
  - 1280 writes and 1280 reads on port A; BIST_B_MEN never high.
  - DONE in cycle 2562; FAIL=0; FAIL_COUNT=0.
- Port A bit 3 stuck-at-1 at address 0x2A:
  - FAIL=1, FAIL_PORT=0, FAIL_ADDR=0x2A, FAIL_COUNT=3 (E1, E3, E5 reads).
- PORT_SEL=11, port B returns inverted data on every read:
  - Port A phase is clean.
  - FAIL_PORT=1, FAIL_ADDR=0x00, FAIL_COUNT=255 (saturated), DONE in cycle 5122.
- START pulsed in cycle 100 of a run: ignored, with unchanged command sequence and DONE cycle. PORT_SEL=00: DONE in cycle 1, no MEN.
- BIST_RST_N low during cycle 700:
  - All outputs go to reset values asynchronously, with BIST_BM all ones.
  - A fresh START after release runs from E0 at address 0.
- RD_LAT=2 with a clean macro: DONE in cycle 2563, FAIL=0.
